// File: rtl/residual_link_pkg.sv
// Shared widths, FSM encoding and destination codes for the residual link.
// The mem_readin side decodes the same code values.
package residual_link_pkg;

  localparam int CODE_W  = 5;
  localparam int RES_W   = 40;
  localparam int WORD_W  = CODE_W + RES_W;
  localparam int ADDR_W  = 6;
  localparam int NUM_MEM = 4;

  localparam logic [CODE_W-1:0] CODE1 = 5'b00001;
  localparam logic [CODE_W-1:0] CODE2 = 5'b00010;
  localparam logic [CODE_W-1:0] CODE3 = 5'b00011;
  localparam logic [CODE_W-1:0] CODE4 = 5'b00100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Memory index 0..3 maps to destination codes CODE1..CODE4.
  function automatic logic [CODE_W-1:0] code_of(input logic [1:0] sel);
    case (sel)
      2'd0:    code_of = CODE1;
      2'd1:    code_of = CODE2;
      2'd2:    code_of = CODE3;
      default: code_of = CODE4;
    endcase
  endfunction

endpackage

// File: rtl/residual_link_tx_rr_arbiter4.sv
// Four-way round-robin arbiter: grants the first requester after the pointer
// (pointer holds the index of the last memory served).
module rr_arbiter4
  import residual_link_pkg::*;
(
  input  logic [NUM_MEM-1:0] req,
  input  logic [1:0]         ptr,
  input  logic               en,
  output logic [NUM_MEM-1:0] grant,
  output logic [1:0]         ptr_next
);

  logic [1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    idx      = ptr;
    if (en) begin
      for (int off = NUM_MEM; off >= 1; off--) begin
        idx = ptr + 2'(off);
        if (req[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
          ptr_next   = idx;
        end
      end
    end
  end

endmodule

// File: rtl/residual_link_tx.sv
// Transmit end of the inter-sector residual link: drains four residual
// memories round-robin, tags each word with its destination code and frames BXs.
module residual_link_tx
  import residual_link_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        BX_in,
  input  logic [5:0]        number_in1,
  input  logic [5:0]        number_in2,
  input  logic [5:0]        number_in3,
  input  logic [5:0]        number_in4,
  output logic [5:0]        read_add1,
  output logic [5:0]        read_add2,
  output logic [5:0]        read_add3,
  output logic [5:0]        read_add4,
  input  logic [39:0]       input_data1,
  input  logic [39:0]       input_data2,
  input  logic [39:0]       input_data3,
  input  logic [39:0]       input_data4,
  input  logic              fifo_full,
  output logic [44:0]       data_residuals,
  output logic              wr_en,
  output logic [3:0]        output_BX,
  output logic              send_BX
);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   num_in     [NUM_MEM];
  logic [RES_W-1:0]    din        [NUM_MEM];
  logic [ADDR_W-1:0]   rem_reg    [NUM_MEM];
  logic [ADDR_W-1:0]   rd_cnt_reg [NUM_MEM];
  logic [NUM_MEM-1:0]  req, grant;
  logic [1:0]          ptr_reg, ptr_arb, inflight_sel_reg;
  logic                inflight_reg, hold_valid_reg;
  logic [WORD_W-1:0]   hold_word_reg, ret_word;
  logic [3:0]          bx_lat_reg, output_bx_reg;
  logic                abort, issue_en, capture, drain, done;

  assign num_in = '{number_in1, number_in2, number_in3, number_in4};
  assign din    = '{input_data1, input_data2, input_data3, input_data4};

  assign read_add1 = rd_cnt_reg[0];
  assign read_add2 = rd_cnt_reg[1];
  assign read_add3 = rd_cnt_reg[2];
  assign read_add4 = rd_cnt_reg[3];

  // A start while busy abandons the current BX, including any word in flight.
  assign abort    = start && (state_reg != IDLE);
  assign issue_en = (state_reg == SEND) && !fifo_full && !hold_valid_reg && !abort;
  assign ret_word = {code_of(inflight_sel_reg), din[inflight_sel_reg]};

  rr_arbiter4 u_arb (
    .req      (req),
    .ptr      (ptr_reg),
    .en       (issue_en),
    .grant    (grant),
    .ptr_next (ptr_arb)
  );

  generate
    for (genvar gi = 0; gi < NUM_MEM; gi++) begin : g_mem
      assign req[gi] = (rem_reg[gi] != '0);

      always_ff @(posedge clk) begin
        if (reset) begin
          rem_reg[gi]    <= '0;
          rd_cnt_reg[gi] <= '0;
        end else if (start) begin
          rem_reg[gi]    <= num_in[gi];
          rd_cnt_reg[gi] <= '0;
        end else if (grant[gi]) begin
          rem_reg[gi]    <= rem_reg[gi] - 1'b1;
          rd_cnt_reg[gi] <= rd_cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SEND;
      SEND:    if (abort) state_next = SEND;
               else if (req == '0) state_next = FLUSH;
      FLUSH:   if (abort) state_next = SEND;
               else if (done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The held word always drains before any new return; the two never coexist.
  always_comb begin
    wr_en          = 1'b0;
    data_residuals = '0;
    capture        = 1'b0;
    drain          = 1'b0;
    if (!abort) begin
      if (hold_valid_reg) begin
        if (!fifo_full) begin
          wr_en          = 1'b1;
          data_residuals = hold_word_reg;
          drain          = 1'b1;
        end
      end else if (inflight_reg) begin
        if (!fifo_full) begin
          wr_en          = 1'b1;
          data_residuals = ret_word;
        end else begin
          capture = 1'b1;
        end
      end
    end
    done      = (state_reg == FLUSH) && !inflight_reg && !hold_valid_reg && !abort;
    send_BX   = done;
    output_BX = done ? bx_lat_reg : output_bx_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg          <= 2'd3;
      inflight_reg     <= 1'b0;
      inflight_sel_reg <= '0;
      hold_valid_reg   <= 1'b0;
      hold_word_reg    <= '0;
      bx_lat_reg       <= '0;
      output_bx_reg    <= '0;
    end else begin
      output_bx_reg <= output_BX;
      if (start) begin
        ptr_reg        <= 2'd3;
        inflight_reg   <= 1'b0;
        hold_valid_reg <= 1'b0;
        bx_lat_reg     <= BX_in;
      end else begin
        ptr_reg      <= ptr_arb;
        inflight_reg <= |grant;
        if (|grant) inflight_sel_reg <= ptr_arb;
        if (capture) begin
          hold_valid_reg <= 1'b1;
          hold_word_reg  <= ret_word;
        end else if (drain) begin
          hold_valid_reg <= 1'b0;
        end
      end
    end
  end

endmodule
